// File: rtl/multadd_pipe.sv
// Three-stage pipelined y = ((x1*x2) >> FRAC) +/- x3 with valid/ready handshake and range flag.
// Optional RESULT_SAT_EN: saturate y on ovf instead of wrapping modulo 2^WIDTH.
module multadd_pipe #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam int PW = 2*WIDTH - FRAC;
  localparam int RW = 2*WIDTH + 1;

  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_x1, r_x2, r_x3_1, r_x3_2;
  logic             r_sub1, r_sub2;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_y;
  logic             r_ovf;

  logic               w_adv;
  logic [2*WIDTH-1:0] w_prod;
  logic [PW-1:0]      w_pshift;
  logic [RW-1:0]      w_pext;
  logic [RW-1:0]      w_x3ext;
  logic [RW-1:0]      w_r;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_y;

  // The whole pipe moves as one; bubbles hold along with data on a stall.
  assign w_adv    = !r_v3 || out_ready;
  assign in_ready = w_adv;

  assign w_prod   = {{WIDTH{1'b0}}, r_x1} * {{WIDTH{1'b0}}, r_x2};
  assign w_pshift = w_prod[2*WIDTH-1:FRAC];

  assign w_pext  = {{(RW-PW){1'b0}}, r_p};
  assign w_x3ext = {{(RW-WIDTH){1'b0}}, r_x3_2};
  assign w_r     = r_sub2 ? (w_pext - w_x3ext) : (w_pext + w_x3ext);

  // A negative result sets the MSB, so any set bit above WIDTH-1 is out of range.
  assign w_ovf = |w_r[RW-1:WIDTH];

`ifdef RESULT_SAT_EN
  assign w_y = !w_ovf    ? w_r[WIDTH-1:0] :
               w_r[RW-1] ? {WIDTH{1'b0}}  : {WIDTH{1'b1}};
`else
  assign w_y = w_r[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_x3_1 <= '0;
      r_sub1 <= 1'b0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_x1   <= x1;
      r_x2   <= x2;
      r_x3_1 <= x3;
      r_sub1 <= sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_p    <= '0;
      r_x3_2 <= '0;
      r_sub2 <= 1'b0;
    end else if (w_adv) begin
      r_v2   <= r_v1;
      r_p    <= w_pshift;
      r_x3_2 <= r_x3_1;
      r_sub2 <= r_sub1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3  <= 1'b0;
      r_y   <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_v3  <= r_v2;
      r_y   <= w_y;
      r_ovf <= w_ovf;
    end
  end

  assign out_valid = r_v3;
  assign y         = r_y;
  assign ovf       = r_ovf;

endmodule
